// File: rtl/ula_seq.sv
// Bit-serial ALU: AND / OR / ADD / SUB (A-B).
// One 1-bit slice is evaluated per clock, LSB first. The operands are latched
// when an operation is accepted. result/carry/zero update together when the
// FSM enters DONE, and they hold until the next operation finishes.
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
    typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11} op_t;

    state_t           state, state_nxt;
    op_t              op_r;
    logic [WIDTH-1:0] a_r, b_r, sr, sr_nxt;
    logic [CW-1:0]    cnt;
    logic             c_r, c_nxt;
    logic             a_bit, b_bit, slice, last_bit, arith;

    assign last_bit = (cnt == LAST);
    assign arith    = (op_r == OP_ADD) || (op_r == OP_SUB);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments only, so every
        // register samples values from before the clock edge.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. start is only looked at in IDLE.
    always_comb begin
        // NOTE: the default comes first, so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One bit slice. SUB is A + ~B + 1, with the +1 preloaded into the carry.
    always_comb begin
        a_bit  = a_r[cnt];
        b_bit  = b_r[cnt] ^ (op_r == OP_SUB);
        slice  = 1'b0;
        c_nxt  = c_r;
        unique case (op_r)
            OP_AND: slice = a_bit & b_bit;
            OP_OR:  slice = a_bit | b_bit;
            default: begin
                slice = a_bit ^ b_bit ^ c_r;
                c_nxt = (a_bit & b_bit) | (c_r & (a_bit ^ b_bit));
            end
        endcase
        sr_nxt = {slice, sr[WIDTH-1:1]};
    end

    // Datapath: latch the operands, shift in slices, and publish the results on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the internal operand and shift registers are reset as well, so that a
        // reset in the middle of an operation leaves no stale state behind.
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= OP_AND;
            sr     <= '0;
            cnt    <= '0;
            c_r    <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    a_r  <= a;
                    b_r  <= b;
                    op_r <= op_t'(op);
                    cnt  <= '0;
                    c_r  <= (op == 2'b11);
                end
                RUN: begin
                    sr  <= sr_nxt;
                    c_r <= c_nxt;
                    if (last_bit) begin
                        result <= sr_nxt;
                        carry  <= arith ? c_nxt : 1'b0;
                        zero   <= (sr_nxt == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Directed testbench for ula_seq with WIDTH=8: a table of back-to-back
// operations, plus hand-written sequences for start-during-RUN and mid-RUN reset.
module tb_ula_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry, zero;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] held = '0;   // result value the DUT should be holding

    ula_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation at the next falling edge and follow it to done. The
    // task returns at the falling edge inside the DONE cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] er, input logic ec);
        int lat, nbusy, overlap, changed;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);                   // accepting edge
        lat = 1; nbusy = 0; overlap = 0; changed = 0;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; op = ~o;   // the latched copies must be used
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            if (busy && done) overlap++;
            if (result !== held) changed++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (busy) overlap++;
        check("latency_edges", lat, W + 1);
        check("busy_cycles", nbusy, W);
        check("busy_done_overlap", overlap, 0);
        check("result_held_in_run", changed, 0);
        check("result", result, er);
        check("carry", carry, ec);
        check("zero", zero, (er == '0));
        held = er;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ndone;
        vecs[0] = '{2'b10, 8'h0F, 8'h01, 8'h10, 1'b0};
        vecs[1] = '{2'b10, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{2'b11, 8'h05, 8'h05, 8'h00, 1'b1};
        vecs[3] = '{2'b11, 8'h03, 8'h05, 8'hFE, 1'b0};
        vecs[4] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[5] = '{2'b01, 8'hF0, 8'h3C, 8'hFC, 1'b0};
        vecs[6] = '{2'b11, 8'h05, 8'h03, 8'h02, 1'b1};
        vecs[7] = '{2'b10, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[8] = '{2'b11, 8'h00, 8'h01, 8'hFF, 1'b0};
        vecs[9] = '{2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b0};

        // Reset state.
        #22;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: back-to-back operations, each one accepted in the IDLE cycle after DONE.
        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cy);

        // A start pulse with a different operand during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h02;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k < 20; k++) begin
            if (k == 3) begin start = 1'b1; a = 8'hAA; end
            if (k == 4) start = 1'b0;
            if (done) ndone++;
            @(negedge clk);
        end
        check("ignore_start_done_pulses", ndone, 1);
        check("ignore_start_result", result, 8'h03);
        check("ignore_start_busy_after", busy, 0);
        held = 8'h03;

        // Reset in RUN cycle 4 abandons the operation without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h10; b = 8'h20;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_result", result, 0);
        check("midrun_rst_zero", zero, 1);
        check("midrun_rst_carry", carry, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        held = '0;
        run_op(2'b10, 8'h10, 8'h20, 8'h30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
